// File: rtl/whack_pkg.sv
// Shared constants for the whack-a-mole datapath: spawner, board and scorer
// agree on the hole-mask width and lifetime encoding through this package.
package whack_pkg;

  localparam int N_HOLES_DEF   = 5;
  localparam int LIFE_W_DEF    = 8;
  localparam int CNT_W_DEF     = 3;

  // A lifetime of zero marks a mole that never expires.
  localparam int LIFE_INFINITE = 0;

  // Width of every hole mask passed between spawner, board and scorer.
  localparam int HOLE_MASK_W   = N_HOLES_DEF;

endpackage

// File: rtl/mole_timer.sv
// One hole of the board: the active flag plus its lifetime countdown.
// Hit and expiry events are combinational so the top can register them
// in the same edge that updates the board.
module mole_timer
  import whack_pkg::*;
#(
  parameter int LIFE_W = LIFE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_en,
  input  logic [LIFE_W-1:0] life,
  input  logic              tick,
  input  logic              hit,
  output logic              active,
  output logic              expire,
  output logic              hit_ok
);

  logic [LIFE_W-1:0] timer;
  logic              timer_is_one;
  logic              timer_is_inf;

  assign timer_is_one = (timer == LIFE_W'(1));
  assign timer_is_inf = (timer == LIFE_W'(LIFE_INFINITE));

  // A hit wins over an expiry on the same hole; load masks both.
  assign hit_ok = active & hit & ~load;
  assign expire = active & tick & timer_is_one & ~hit & ~load;

  // Load replaces the mole, hit/expiry retires it, tick counts it down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      timer  <= '0;
    end else if (load) begin
      active <= load_en;
      timer  <= load_en ? life : '0;
    end else if (hit_ok || expire) begin
      active <= 1'b0;
      timer  <= '0;
    end else if (active && tick && !timer_is_inf && !timer_is_one) begin
      timer  <= timer - LIFE_W'(1);
    end
  end

endmodule

// File: rtl/board_tracker.sv
// Active-mole board: per-hole lifetime timers plus registered hit, miss,
// whiff and board-cleared pulses for the score and miss counters.
module board_tracker
  import whack_pkg::*;
#(
  parameter int N_HOLES = HOLE_MASK_W,
  parameter int LIFE_W  = LIFE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [N_HOLES-1:0] load_mask,
  input  logic [LIFE_W-1:0]  life_ticks,
  input  logic               tick,
  input  logic [N_HOLES-1:0] hit_pulse,
  output logic [N_HOLES-1:0] board_state,
  output logic               score_trigger,
  output logic [CNT_W-1:0]   hit_count,
  output logic               miss_trigger,
  output logic [N_HOLES-1:0] miss_mask,
  output logic               whiff_trigger,
  output logic               clear_pulse
);

  logic [N_HOLES-1:0] hit_ok_v;
  logic [N_HOLES-1:0] expire_v;
  logic [N_HOLES-1:0] next_board;
  logic [N_HOLES-1:0] whiff_v;

  // Popcount clipped to the largest value hit_count can carry.
  function automatic logic [CNT_W-1:0] sat_popcount(input logic [N_HOLES-1:0] v);
    int n;
    n = 0;
    for (int k = 0; k < N_HOLES; k++) n += int'(v[k]);
    if (n >= (1 << CNT_W)) return {CNT_W{1'b1}};
    return CNT_W'(n);
  endfunction

  for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
    mole_timer #(.LIFE_W(LIFE_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .load_en (load_mask[i]),
      .life    (life_ticks),
      .tick    (tick),
      .hit     (hit_pulse[i]),
      .active  (board_state[i]),
      .expire  (expire_v[i]),
      .hit_ok  (hit_ok_v[i])
    );
  end

  // Board after this edge when no load is pending; hit_ok/expire already
  // read as zero during a load, so this only matters for clear detection.
  assign next_board = board_state & ~(hit_ok_v | expire_v);
  assign whiff_v    = hit_pulse & ~board_state;

  // Event pulses, registered so every output changes on the same edge as the board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_trigger <= 1'b0;
      hit_count     <= '0;
      miss_trigger  <= 1'b0;
      miss_mask     <= '0;
      whiff_trigger <= 1'b0;
      clear_pulse   <= 1'b0;
    end else begin
      score_trigger <= |hit_ok_v;
      hit_count     <= sat_popcount(hit_ok_v);
      miss_trigger  <= |expire_v;
      miss_mask     <= expire_v;
      whiff_trigger <= ~load & (|whiff_v);
      clear_pulse   <= ~load & (|board_state) & ~(|next_board);
    end
  end

endmodule

// File: tb/tb_board_tracker.sv
// Scoreboard bench for board_tracker: a default 5-hole instance and an
// 8-hole instance with a 2-bit hit_count.
`timescale 1ns/1ps
module tb_board_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (5 holes, 8-bit life, 3-bit count)
  logic       a_load = 0, a_tick = 0;
  logic [4:0] a_mask = 0, a_hit = 0;
  logic [7:0] a_life = 0;
  logic [4:0] a_board, a_mm;
  logic [2:0] a_hc;
  logic       a_sc, a_ms, a_wf, a_cl;

  // Instance B: 8 holes, 2-bit count
  logic       b_load = 0, b_tick = 0;
  logic [7:0] b_mask = 0, b_hit = 0;
  logic [7:0] b_life = 0;
  logic [7:0] b_board, b_mm;
  logic [1:0] b_hc;
  logic       b_sc, b_ms, b_wf, b_cl;

  board_tracker dut_a (
    .clk(clk), .rst_n(rst_n), .load(a_load), .load_mask(a_mask),
    .life_ticks(a_life), .tick(a_tick), .hit_pulse(a_hit),
    .board_state(a_board), .score_trigger(a_sc), .hit_count(a_hc),
    .miss_trigger(a_ms), .miss_mask(a_mm), .whiff_trigger(a_wf),
    .clear_pulse(a_cl)
  );

  board_tracker #(.N_HOLES(8), .LIFE_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(b_load), .load_mask(b_mask),
    .life_ticks(b_life), .tick(b_tick), .hit_pulse(b_hit),
    .board_state(b_board), .score_trigger(b_sc), .hit_count(b_hc),
    .miss_trigger(b_ms), .miss_mask(b_mm), .whiff_trigger(b_wf),
    .clear_pulse(b_cl)
  );

  typedef struct {
    int          due;
    bit          which;
    logic [15:0] board;
    logic        sc;
    logic [3:0]  hc;
    logic        ms;
    logic [15:0] mm;
    logic        wf;
    logic        cl;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int due, input bit which, input logic [15:0] eb,
                      input logic es, input logic [3:0] ehc, input logic em,
                      input logic [15:0] emm, input logic ew, input logic ecl,
                      input string nm);
    exp_t e;
    e.due = due; e.which = which; e.board = eb; e.sc = es; e.hc = ehc;
    e.ms = em; e.mm = emm; e.wf = ew; e.cl = ecl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One cycle of stimulus on one instance; the other idles.
  task automatic drive(input bit which, input logic ld, input logic [15:0] lm,
                       input logic [7:0] lt, input logic tk, input logic [15:0] hp,
                       input logic [15:0] eb, input logic es, input logic [3:0] ehc,
                       input logic em, input logic [15:0] emm, input logic ew,
                       input logic ecl, input string nm);
    @(posedge clk);
    #1;
    a_load = 0; a_mask = '0; a_life = '0; a_tick = 0; a_hit = '0;
    b_load = 0; b_mask = '0; b_life = '0; b_tick = 0; b_hit = '0;
    if (which == 1'b0) begin
      a_load = ld; a_mask = lm[4:0]; a_life = lt; a_tick = tk; a_hit = hp[4:0];
    end else begin
      b_load = ld; b_mask = lm[7:0]; b_life = lt; b_tick = tk; b_hit = hp[7:0];
    end
    push(cyc + 1, which, eb, es, ehc, em, emm, ew, ecl, nm);
  endtask

  // Monitor: compares any expectation that has come due.
  initial begin : monitor
    exp_t        e;
    string       nm;
    logic [15:0] ab, amm;
    logic [3:0]  ahc;
    logic        asc, ams, awf, acl;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.which == 1'b0) begin
          ab = {11'b0, a_board}; amm = {11'b0, a_mm}; ahc = {1'b0, a_hc};
          asc = a_sc; ams = a_ms; awf = a_wf; acl = a_cl;
        end else begin
          ab = {8'b0, b_board}; amm = {8'b0, b_mm}; ahc = {2'b0, b_hc};
          asc = b_sc; ams = b_ms; awf = b_wf; acl = b_cl;
        end
        checks++;
        if (ab !== e.board || asc !== e.sc || ahc !== e.hc || ams !== e.ms ||
            amm !== e.mm || awf !== e.wf || acl !== e.cl) begin
          errors++;
          $display("FAIL %s dut%0d got board=%h sc=%b hc=%0d ms=%b mm=%h wf=%b cl=%b want board=%h sc=%b hc=%0d ms=%b mm=%h wf=%b cl=%b",
                   nm, e.which, ab, asc, ahc, ams, amm, awf, acl,
                   e.board, e.sc, e.hc, e.ms, e.mm, e.wf, e.cl);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout cycles=%0d pending=%0d", cyc, exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (2) @(posedge clk);
    #1;
    push(cyc, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, "reset_a");
    push(cyc, 1, 16'h0, 0, 0, 0, 16'h0, 0, 0, "reset_b");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Load, double hit, three-tick expiry
    drive(0, 1, 16'h16, 8'd3, 0, 16'h00, 16'h16, 0, 0, 0, 16'h00, 0, 0, "load_10110");
    drive(0, 0, 16'h00, 8'd0, 0, 16'h06, 16'h10, 1, 2, 0, 16'h00, 0, 0, "hit_two");
    drive(0, 0, 16'h00, 8'd0, 1, 16'h00, 16'h10, 0, 0, 0, 16'h00, 0, 0, "tick_1");
    drive(0, 0, 16'h00, 8'd0, 1, 16'h00, 16'h10, 0, 0, 0, 16'h00, 0, 0, "tick_2");
    drive(0, 0, 16'h00, 8'd0, 1, 16'h00, 16'h00, 0, 0, 1, 16'h10, 0, 1, "expire_clear");

    // Hit beats expiry on the same hole
    drive(0, 1, 16'h01, 8'd1, 0, 16'h00, 16'h01, 0, 0, 0, 16'h00, 0, 0, "load_h0_life1");
    drive(0, 0, 16'h00, 8'd0, 1, 16'h01, 16'h00, 1, 1, 0, 16'h00, 0, 1, "hit_beats_expiry");

    // Hit on one hole and expiry on another in one cycle
    drive(0, 1, 16'h03, 8'd1, 0, 16'h00, 16'h03, 0, 0, 0, 16'h00, 0, 0, "load_h01_life1");
    drive(0, 0, 16'h00, 8'd0, 1, 16'h01, 16'h00, 1, 1, 1, 16'h02, 0, 1, "hit_and_miss");

    // Load of an empty mask never clears; tick on empty board is silent
    drive(0, 1, 16'h10, 8'd0, 0, 16'h00, 16'h10, 0, 0, 0, 16'h00, 0, 0, "load_h4");
    drive(0, 1, 16'h00, 8'd0, 0, 16'h00, 16'h00, 0, 0, 0, 16'h00, 0, 0, "load_zero_no_clear");
    drive(0, 0, 16'h00, 8'd0, 1, 16'h00, 16'h00, 0, 0, 0, 16'h00, 0, 0, "tick_empty");

    // Load priority over hits, then infinite lifetime
    drive(0, 1, 16'h09, 8'd0, 0, 16'h1F, 16'h09, 0, 0, 0, 16'h00, 0, 0, "load_priority");
    for (int i = 0; i < 300; i++)
      drive(0, 0, 16'h00, 8'd0, 1, 16'h00, 16'h09, 0, 0, 0, 16'h00, 0, 0, "infinite_life");

    // Whiffs
    drive(0, 0, 16'h00, 8'd0, 0, 16'h02, 16'h09, 0, 0, 0, 16'h00, 1, 0, "whiff");
    drive(0, 0, 16'h00, 8'd0, 0, 16'h03, 16'h08, 1, 1, 0, 16'h00, 1, 0, "hit_plus_whiff");

    // Asynchronous reset between clock edges
    @(posedge clk);
    @(negedge clk);
    #2;
    a_hit = '0;
    rst_n = 1'b0;
    push(cyc, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, "async_reset_a");
    push(cyc, 1, 16'h0, 0, 0, 0, 16'h0, 0, 0, "async_reset_b");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturating hit_count on the 8-hole instance
    drive(1, 1, 16'h0F, 8'd3, 0, 16'h00, 16'h0F, 0, 0, 0, 16'h00, 0, 0, "b_load_0f");
    drive(1, 0, 16'h00, 8'd0, 0, 16'h0F, 16'h00, 1, 3, 0, 16'h00, 0, 1, "b_sat_four");
    drive(1, 1, 16'hFF, 8'd3, 0, 16'h00, 16'hFF, 0, 0, 0, 16'h00, 0, 0, "b_load_ff");
    drive(1, 0, 16'h00, 8'd0, 0, 16'hF0, 16'h0F, 1, 3, 0, 16'h00, 0, 0, "b_sat_upper");
    drive(1, 0, 16'h00, 8'd0, 0, 16'h03, 16'h0C, 1, 2, 0, 16'h00, 0, 0, "b_hit_two");
    drive(1, 0, 16'h00, 8'd0, 0, 16'h0C, 16'h00, 1, 2, 0, 16'h00, 0, 1, "b_clear");
    drive(1, 0, 16'h00, 8'd0, 0, 16'h00, 16'h00, 0, 0, 0, 16'h00, 0, 0, "b_idle");

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
